// File: rtl/cp0_irq_ctrl.sv
// CP0 interrupt controller: STATUS/CAUSE/EPCR/EHBR register file, edge-captured
// interrupt pending bits, and IDLE/HANDLER sequencing with forced-jump generation.
module cp0_irq_ctrl #(
    parameter int N_IRQ      = 8,
    parameter bit VECTORED   = 1'b0,
    parameter int VEC_STRIDE = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       oper,
    input  logic [4:0]       addr_r,
    output logic [31:0]      data_r,
    input  logic [4:0]       addr_w,
    input  logic [31:0]      data_w,
    input  logic             ir_en,
    input  logic [N_IRQ-1:0] ir_in,
    input  logic [31:0]      ret_addr,
    output logic             jump_en,
    output logic [31:0]      jump_addr
);

    // Encodings: 00 none, 01 MFC0 (reads are combinational, no action needed),
    // 10 MTC0, 11 ERET.
    localparam logic [1:0] EXE_CP_MTC0  = 2'b10;
    localparam logic [1:0] EXE_CP0_ERET = 2'b11;
    localparam int         STRIDE_SH    = $clog2(VEC_STRIDE);

    localparam logic [4:0] ADDR_STATUS = 5'd0;
    localparam logic [4:0] ADDR_CAUSE  = 5'd1;
    localparam logic [4:0] ADDR_EPCR   = 5'd2;
    localparam logic [4:0] ADDR_EHBR   = 5'd3;

    typedef enum logic {
        IDLE    = 1'b0,
        HANDLER = 1'b1
    } state_t;

    state_t           state;
    logic             ie;
    logic [N_IRQ-1:0] im;
    logic [N_IRQ-1:0] ip;
    logic [N_IRQ-1:0] ir_prev;
    logic             armed;
    logic [4:0]       code;
    logic [31:0]      epcr;
    logic [31:0]      ehbr;

    logic [N_IRQ-1:0] act;
    logic [N_IRQ-1:0] sel_mask;
    logic [N_IRQ-1:0] rise;
    logic [N_IRQ-1:0] ip_clr;
    logic [4:0]       sel_idx;
    logic [31:0]      vec_off;
    logic             take;
    logic             eret;
    logic             mtc0;

    assign act  = ip & im;
    assign take = (state == IDLE) & ir_en & ie & (|act);
    // A take flushes whatever CP0 operation sits in EXE this cycle.
    assign eret = (oper == EXE_CP0_ERET) & ~take;
    assign mtc0 = (oper == EXE_CP_MTC0) & ~take;

    // The first edge after reset only loads history, so a line already high
    // at reset release does not look like a new request.
    assign rise = armed ? (ir_in & ~ir_prev) : '0;

    always_comb begin
        sel_idx  = '0;
        sel_mask = '0;
        for (int i = N_IRQ - 1; i >= 0; i--) begin
            if (act[i]) begin
                sel_idx     = 5'(i);
                sel_mask    = '0;
                sel_mask[i] = 1'b1;
            end
        end
    end

    always_comb begin
        ip_clr = '0;
        if (mtc0 && addr_w == ADDR_CAUSE) begin
            ip_clr = data_w[8 +: N_IRQ];
        end
        if (take) begin
            ip_clr = ip_clr | sel_mask;
        end
    end

    assign vec_off = {27'd0, sel_idx} << STRIDE_SH;

    always_comb begin
        jump_addr = ehbr;
        if (take) begin
            jump_addr = VECTORED ? (ehbr + vec_off) : ehbr;
        end else if (eret) begin
            jump_addr = epcr;
        end
    end

    assign jump_en = ~rst & (take | eret);

    always_comb begin
        data_r = '0;
        case (addr_r)
            ADDR_STATUS: begin
                data_r[0]          = ie;
                data_r[8 +: N_IRQ] = im;
            end
            ADDR_CAUSE: begin
                data_r[8 +: N_IRQ] = ip;
                data_r[6:2]        = code;
            end
            ADDR_EPCR: data_r = epcr;
            ADDR_EHBR: data_r = ehbr;
            default:   data_r = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            ie      <= 1'b0;
            im      <= '0;
            ip      <= '0;
            ir_prev <= '0;
            armed   <= 1'b0;
            code    <= '0;
            epcr    <= '0;
            ehbr    <= '0;
        end else begin
            armed   <= 1'b1;
            ir_prev <= ir_in;
            // Set after clear: a new edge beats a same-cycle clear.
            ip      <= (ip & ~ip_clr) | rise;

            if (take) begin
                epcr <= ret_addr;
                code <= sel_idx;
            end

            if (mtc0) begin
                case (addr_w)
                    ADDR_STATUS: begin
                        ie <= data_w[0];
                        im <= data_w[8 +: N_IRQ];
                    end
                    ADDR_EPCR: epcr <= data_w;
                    ADDR_EHBR: ehbr <= data_w;
                    default: ;
                endcase
            end

            case (state)
                IDLE:    if (take) state <= HANDLER;
                HANDLER: if (eret) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cp0_irq_ctrl.sv
// Directed bench for cp0_irq_ctrl: two instances (single and vectored handler
// address) share all inputs so each scenario checks both jump targets.
module tb_cp0_irq_ctrl;

    localparam logic [1:0] OP_NONE = 2'b00;
    localparam logic [1:0] OP_MTC0 = 2'b10;
    localparam logic [1:0] OP_ERET = 2'b11;

    logic        clk;
    logic        rst;
    logic [1:0]  oper;
    logic [4:0]  addr_r;
    logic [4:0]  addr_w;
    logic [31:0] data_w;
    logic        ir_en;
    logic [7:0]  ir_in;
    logic [31:0] ret_addr;

    logic [31:0] data_r0, data_r1;
    logic        jump_en0, jump_en1;
    logic [31:0] jump_addr0, jump_addr1;

    int vectors = 0;
    int errors  = 0;

    cp0_irq_ctrl #(.N_IRQ(8), .VECTORED(1'b0), .VEC_STRIDE(32)) dut0 (
        .clk(clk), .rst(rst), .oper(oper), .addr_r(addr_r), .data_r(data_r0),
        .addr_w(addr_w), .data_w(data_w), .ir_en(ir_en), .ir_in(ir_in),
        .ret_addr(ret_addr), .jump_en(jump_en0), .jump_addr(jump_addr0)
    );

    cp0_irq_ctrl #(.N_IRQ(8), .VECTORED(1'b1), .VEC_STRIDE(32)) dut1 (
        .clk(clk), .rst(rst), .oper(oper), .addr_r(addr_r), .data_r(data_r1),
        .addr_w(addr_w), .data_w(data_w), .ir_en(ir_en), .ir_in(ir_in),
        .ret_addr(ret_addr), .jump_en(jump_en1), .jump_addr(jump_addr1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [4:0] a, output logic [31:0] d);
        addr_r = a;
        #1;
        d = data_r0;
    endtask

    task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
        oper   = OP_MTC0;
        addr_w = a;
        data_w = d;
        tick();
        oper   = OP_NONE;
        addr_w = '0;
        data_w = '0;
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        oper     = OP_NONE;
        addr_w   = '0;
        data_w   = '0;
        ir_en    = 1'b0;
        ir_in    = '0;
        ret_addr = '0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        rst = 1'b1; oper = OP_ERET; addr_w = '0; data_w = '0;
        ir_en = 1'b1; ir_in = 8'h08; ret_addr = 32'h1234;
        #2;
        vectors++;
        if (jump_en0 !== 1'b0) begin errors++; $display("FAIL reset_jump_en got %b want 0", jump_en0); end
        for (int a = 0; a < 4; a++) begin
            rd(5'(a), d);
            vectors++;
            if (d !== 32'h0) begin errors++; $display("FAIL reset_reg%0d got %h want 00000000", a, d); end
        end
        tick();
        tick();
        rst = 1'b0; oper = OP_NONE; ir_en = 1'b0;
        tick();
        tick();
        rd(5'd1, d);
        vectors++;
        if (d !== 32'h0) begin errors++; $display("FAIL reset_release_edge cause got %h want 00000000", d); end
        ir_in = '0;
    endtask

    task automatic test_entry();
        logic [31:0] d;
        do_reset();
        mtc0(5'd0, 32'h0000_0301);
        mtc0(5'd3, 32'h0000_0100);
        ret_addr = 32'h40; ir_en = 1'b1; ir_in = 8'h02;
        #1;
        vectors++;
        if (jump_en0 !== 1'b0) begin errors++; $display("FAIL entry_early got %b want 0", jump_en0); end
        tick();
        ir_in = '0;
        #1;
        vectors++;
        if (jump_en0 !== 1'b1 || jump_addr0 !== 32'h100) begin
            errors++; $display("FAIL entry_jump got %b/%h want 1/00000100", jump_en0, jump_addr0);
        end
        vectors++;
        if (jump_addr1 !== 32'h120) begin errors++; $display("FAIL entry_vec got %h want 00000120", jump_addr1); end
        tick();
        vectors++;
        if (jump_en0 !== 1'b0) begin errors++; $display("FAIL entry_one_cycle got %b want 0", jump_en0); end
        rd(5'd2, d);
        vectors++;
        if (d !== 32'h40) begin errors++; $display("FAIL entry_epcr got %h want 00000040", d); end
        rd(5'd1, d);
        vectors++;
        if (d !== 32'h4) begin errors++; $display("FAIL entry_cause got %h want 00000004", d); end
        oper = OP_ERET;
        #1;
        vectors++;
        if (jump_en0 !== 1'b1 || jump_addr0 !== 32'h40) begin
            errors++; $display("FAIL entry_eret got %b/%h want 1/00000040", jump_en0, jump_addr0);
        end
        tick();
        oper = OP_NONE;
        #1;
        vectors++;
        if (jump_en0 !== 1'b0) begin errors++; $display("FAIL entry_after_eret got %b want 0", jump_en0); end
        ir_en = 1'b0;
    endtask

    task automatic test_priority();
        logic [31:0] d;
        do_reset();
        mtc0(5'd0, 32'h0000_FF01);
        mtc0(5'd3, 32'h0000_1000);
        ret_addr = 32'h200; ir_in = 8'h24;
        tick();
        ir_in = '0;
        rd(5'd1, d);
        vectors++;
        if (d !== 32'h2400) begin errors++; $display("FAIL prio_pending got %h want 00002400", d); end
        ir_en = 1'b1;
        #1;
        vectors++;
        if (jump_en1 !== 1'b1 || jump_addr1 !== 32'h1040) begin
            errors++; $display("FAIL prio_line2 got %b/%h want 1/00001040", jump_en1, jump_addr1);
        end
        tick();
        vectors++;
        if (jump_en1 !== 1'b0) begin errors++; $display("FAIL prio_handler got %b want 0", jump_en1); end
        rd(5'd1, d);
        vectors++;
        if (d !== 32'h2008) begin errors++; $display("FAIL prio_cause got %h want 00002008", d); end
        oper = OP_ERET;
        #1;
        vectors++;
        if (jump_en1 !== 1'b1 || jump_addr1 !== 32'h200) begin
            errors++; $display("FAIL prio_eret got %b/%h want 1/00000200", jump_en1, jump_addr1);
        end
        tick();
        oper = OP_NONE;
        #1;
        vectors++;
        if (jump_en1 !== 1'b1 || jump_addr1 !== 32'h10A0) begin
            errors++; $display("FAIL prio_line5 got %b/%h want 1/000010a0", jump_en1, jump_addr1);
        end
        tick();
        ir_en = 1'b0;
        rd(5'd1, d);
        vectors++;
        if (d !== 32'h14) begin errors++; $display("FAIL prio_cause5 got %h want 00000014", d); end
    endtask

    task automatic test_mask_ie();
        logic [31:0] d;
        do_reset();
        mtc0(5'd0, 32'h0000_0800);
        ir_en = 1'b1; ir_in = 8'h18;
        tick();
        ir_in = '0;
        #1;
        vectors++;
        if (jump_en0 !== 1'b0) begin errors++; $display("FAIL mask_ie0 got %b want 0", jump_en0); end
        rd(5'd1, d);
        vectors++;
        if (d !== 32'h1800) begin errors++; $display("FAIL mask_pending got %h want 00001800", d); end
        ir_en = 1'b0;
        mtc0(5'd0, 32'h0000_0801);
        #1;
        vectors++;
        if (jump_en0 !== 1'b0) begin errors++; $display("FAIL mask_no_iren got %b want 0", jump_en0); end
        ir_en = 1'b1;
        #1;
        vectors++;
        if (jump_en0 !== 1'b1 || jump_addr0 !== 32'h0 || jump_addr1 !== 32'h60) begin
            errors++; $display("FAIL mask_take got %b/%h/%h want 1/00000000/00000060", jump_en0, jump_addr0, jump_addr1);
        end
        tick();
        ir_en = 1'b0;
        rd(5'd1, d);
        vectors++;
        if (d !== 32'h100C) begin errors++; $display("FAIL mask_cause got %h want 0000100c", d); end
    endtask

    task automatic test_nesting();
        logic [31:0] d;
        do_reset();
        mtc0(5'd0, 32'h0000_FF01);
        mtc0(5'd3, 32'h0000_0300);
        ret_addr = 32'h80; ir_en = 1'b1; ir_in = 8'h02;
        tick();
        ir_in = '0;
        tick();
        ir_in = 8'h01;
        tick();
        ir_in = '0;
        #1;
        vectors++;
        if (jump_en0 !== 1'b0) begin errors++; $display("FAIL nest_blocked got %b want 0", jump_en0); end
        rd(5'd1, d);
        vectors++;
        if (d !== 32'h104) begin errors++; $display("FAIL nest_cause got %h want 00000104", d); end
        oper = OP_ERET;
        #1;
        vectors++;
        if (jump_en0 !== 1'b1 || jump_addr0 !== 32'h80) begin
            errors++; $display("FAIL nest_eret got %b/%h want 1/00000080", jump_en0, jump_addr0);
        end
        tick();
        oper = OP_NONE;
        #1;
        vectors++;
        if (jump_en0 !== 1'b1 || jump_addr0 !== 32'h300) begin
            errors++; $display("FAIL nest_take0 got %b/%h want 1/00000300", jump_en0, jump_addr0);
        end
        tick();
        ir_en = 1'b0;
        rd(5'd1, d);
        vectors++;
        if (d !== 32'h0) begin errors++; $display("FAIL nest_cause0 got %h want 00000000", d); end
    endtask

    task automatic test_conflicts();
        logic [31:0] d;
        do_reset();
        mtc0(5'd0, 32'h0000_FF01);
        mtc0(5'd3, 32'h0000_0100);
        ret_addr = 32'h60; ir_in = 8'h04;
        tick();
        ir_in = '0;
        ir_en = 1'b1; oper = OP_MTC0; addr_w = 5'd3; data_w = 32'hDEAD_0000;
        #1;
        vectors++;
        if (jump_en0 !== 1'b1 || jump_addr0 !== 32'h100) begin
            errors++; $display("FAIL conf_take got %b/%h want 1/00000100", jump_en0, jump_addr0);
        end
        tick();
        oper = OP_NONE; ir_en = 1'b0; addr_w = '0; data_w = '0;
        rd(5'd3, d);
        vectors++;
        if (d !== 32'h100) begin errors++; $display("FAIL conf_ehbr got %h want 00000100", d); end
        rd(5'd2, d);
        vectors++;
        if (d !== 32'h60) begin errors++; $display("FAIL conf_epcr got %h want 00000060", d); end
        ir_in = 8'h10;
        tick();
        ir_in = '0;
        tick();
        rd(5'd1, d);
        vectors++;
        if (d !== 32'h1008) begin errors++; $display("FAIL conf_pend got %h want 00001008", d); end
        ir_in = 8'h10;
        mtc0(5'd1, 32'h0000_107C);
        ir_in = '0;
        rd(5'd1, d);
        vectors++;
        if (d !== 32'h1008) begin errors++; $display("FAIL conf_set_wins got %h want 00001008", d); end
        mtc0(5'd1, 32'h0000_1000);
        rd(5'd1, d);
        vectors++;
        if (d !== 32'h8) begin errors++; $display("FAIL conf_w1c got %h want 00000008", d); end
    endtask

    task automatic test_async_reset();
        logic [31:0] d;
        do_reset();
        mtc0(5'd0, 32'h0000_FF01);
        mtc0(5'd3, 32'h0000_0100);
        ret_addr = 32'h44; ir_en = 1'b1; ir_in = 8'h01;
        tick();
        ir_in = '0;
        tick();
        ir_in = 8'h40;
        tick();
        ir_in = '0;
        rd(5'd1, d);
        vectors++;
        if (d !== 32'h4000) begin errors++; $display("FAIL arst_pre_cause got %h want 00004000", d); end
        oper = OP_ERET;
        #1;
        rst = 1'b1;
        #1;
        vectors++;
        if (jump_en0 !== 1'b0) begin errors++; $display("FAIL arst_jump_en got %b want 0", jump_en0); end
        for (int a = 0; a < 4; a++) begin
            rd(5'(a), d);
            vectors++;
            if (d !== 32'h0) begin errors++; $display("FAIL arst_reg%0d got %h want 00000000", a, d); end
        end
        oper = OP_NONE; ir_en = 1'b0;
        tick();
        rst = 1'b0;
        mtc0(5'd0, 32'h0000_FF01);
        ir_in = 8'h01;
        tick();
        ir_in = '0; ir_en = 1'b1;
        #1;
        vectors++;
        if (jump_en0 !== 1'b1) begin errors++; $display("FAIL arst_idle_take got %b want 1", jump_en0); end
        tick();
        ir_en = 1'b0;
    endtask

    initial begin
        addr_r = '0;
        test_reset();
        test_entry();
        test_priority();
        test_mask_ie();
        test_nesting();
        test_conflicts();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
